// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter: grants one input for a whole packet, frees it on
// pkt_end or dropped request. Optional hold watchdog is compiled in by ROUTER_ARB_TIMEOUT_EN.
module router_out_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int ID_W      = 4,
  parameter int MAX_HOLD  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] pkt_end,
  output logic [NUM_PORTS-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 grant_valid,
  output logic [NUM_PORTS-1:0] busy_n,
  output logic                 timeout,
  output logic                 dbg_state,
  output logic [ID_W-1:0]      dbg_rr_ptr
);

  // Handshake: req[i] is a level held while input i has a frame for this output;
  // grant[i] is asserted from the edge after arbitration until the edge after release.
  // pkt_end[i] is a one-cycle pulse and only counts for the current owner.

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  if (ID_W != $clog2(NUM_PORTS) || MAX_HOLD < 2) begin : g_bad_cfg
    $error("router_out_arbiter: inconsistent NUM_PORTS/ID_W/MAX_HOLD");
  end

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [NUM_PORTS-1:0] busy_n_q, busy_n_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic                 normal_rel;
  logic                 expire;
  logic [ID_W-1:0]      owner_inc;

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  assign expire = (state_q == HOLD) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_PORTS;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign owner_inc = (grant_id_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    normal_rel    = pkt_end[grant_id_q] || !req[grant_id_q];
`ifdef ROUTER_ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
        if (win_found) begin
          grant_d[win_id] = 1'b1;
          grant_id_d      = win_id;
          grant_valid_d   = 1'b1;
          state_d         = HOLD;
`ifdef ROUTER_ARB_TIMEOUT_EN
          hold_cnt_d      = '0;
`endif
        end
      end
      HOLD: begin
        if (normal_rel || expire) begin
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = owner_inc;
          state_d       = IDLE;
          // A release that would have happened anyway is not reported as a timeout.
          timeout_d     = expire && !normal_rel;
        end else begin
`ifdef ROUTER_ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_n_d = ~(req & ~grant_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      busy_n_q      <= '1;
      timeout_q     <= 1'b0;
`ifdef ROUTER_ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      busy_n_q      <= busy_n_d;
      timeout_q     <= timeout_d;
`ifdef ROUTER_ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign busy_n      = busy_n_q;
  assign timeout     = timeout_q;
  assign dbg_state   = state_q;
  assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Bench for router_out_arbiter: vector tables, fairness and random round-robin sequences,
// and the watchdog sequence when ROUTER_ARB_TIMEOUT_EN is defined.
module tb_router_out_arbiter;

  localparam int W = 16 + 4 + 1 + 16 + 1;

  typedef struct packed {
    logic        rst;
    logic [15:0] req;
    logic [15:0] pe;
    logic [15:0] grant;
    logic [3:0]  id;
    logic        valid;
    logic [15:0] busy_n;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [15:0] req;
  logic [15:0] pkt_end;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic [15:0] busy_n;
  logic        timeout;
  logic        dbg_state;
  logic [3:0]  dbg_rr_ptr;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  router_out_arbiter #(.NUM_PORTS(16), .ID_W(4), .MAX_HOLD(8)) dut (
    .clock(clock), .reset(reset), .req(req), .pkt_end(pkt_end),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid),
    .busy_n(busy_n), .timeout(timeout), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic r, input logic [15:0] rq, input logic [15:0] pe,
                              input logic [15:0] g, input logic [3:0] id, input logic v,
                              input logic [15:0] b);
    vec_t x;
    x.rst = r; x.req = rq; x.pe = pe; x.grant = g; x.id = id; x.valid = v; x.busy_n = b;
    return x;
  endfunction

  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] j;
    for (int k = 0; k < 16; k++) begin
      j = p + 4'(k);
      if (r[j]) return j;
    end
    return 4'd0;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req_v);
    end
  endtask

  task automatic check_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
      return;
    end
    e = exp_q.pop_front();
    cmp("grant",       grant,              e[37:22]);
    cmp("grant_id",    16'(grant_id),      16'(e[21:18]));
    cmp("grant_valid", 16'(grant_valid),   16'(e[17]));
    cmp("busy_n",      busy_n,             e[16:1]);
    cmp("timeout",     16'(timeout),       16'(e[0]));
  endtask

  task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] pe,
                      input logic [15:0] eg, input logic [3:0] eid, input logic ev,
                      input logic [15:0] eb, input logic et);
    reset   = r;
    req     = rq;
    pkt_end = pe;
    exp_q.push_back({eg, eid, ev, eb, et});
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic run_vec(input vec_t v);
    step(v.rst, v.req, v.pe, v.grant, v.id, v.valid, v.busy_n, 1'b0);
  endtask

  initial begin
    vec_t tbl_a[5];
    vec_t tbl_b[21];
    logic [3:0]  ptr;
    logic [3:0]  w;
    logic [15:0] rq;
    logic [15:0] rq2;
    logic [15:0] oh;

    tbl_a[0] = mk(1, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 0, 16'hFFFF);
    tbl_a[1] = mk(1, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 0, 16'hFFFF);
    tbl_a[2] = mk(1, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 0, 16'hFFFF);
    tbl_a[3] = mk(0, 16'hFFFF, 16'h0000, 16'h0001, 4'd0, 1, 16'h0001);
    tbl_a[4] = mk(0, 16'hFFFF, 16'h0001, 16'h0000, 4'd0, 0, 16'h0000);

    // rr_ptr=1 on entry: serve 13, then wrap/skip, non-owner pkt_end, reset mid-packet.
    tbl_b[0]  = mk(0, 16'h2000, 16'h0000, 16'h2000, 4'd13, 1, 16'hFFFF);
    tbl_b[1]  = mk(0, 16'h2000, 16'h2000, 16'h0000, 4'd0,  0, 16'hDFFF);
    tbl_b[2]  = mk(0, 16'h0009, 16'h0000, 16'h0001, 4'd0,  1, 16'hFFF7);
    tbl_b[3]  = mk(0, 16'h0009, 16'h0001, 16'h0000, 4'd0,  0, 16'hFFF6);
    tbl_b[4]  = mk(0, 16'h0009, 16'h0000, 16'h0008, 4'd3,  1, 16'hFFFE);
    tbl_b[5]  = mk(0, 16'h0009, 16'h0008, 16'h0000, 4'd0,  0, 16'hFFF6);
    tbl_b[6]  = mk(0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 16'hFFFF);
    tbl_b[7]  = mk(0, 16'h0020, 16'h0000, 16'h0020, 4'd5,  1, 16'hFFFF);
    tbl_b[8]  = mk(0, 16'h0120, 16'h0100, 16'h0020, 4'd5,  1, 16'hFEFF);
    tbl_b[9]  = mk(0, 16'h0120, 16'h0000, 16'h0020, 4'd5,  1, 16'hFEFF);
    tbl_b[10] = mk(0, 16'h0100, 16'h0000, 16'h0000, 4'd0,  0, 16'hFEFF);
    tbl_b[11] = mk(0, 16'h0100, 16'h0000, 16'h0100, 4'd8,  1, 16'hFFFF);
    tbl_b[12] = mk(0, 16'h0100, 16'h0100, 16'h0000, 4'd0,  0, 16'hFEFF);
    tbl_b[13] = mk(0, 16'h0080, 16'h0000, 16'h0080, 4'd7,  1, 16'hFFFF);
    tbl_b[14] = mk(0, 16'h0080, 16'h0000, 16'h0080, 4'd7,  1, 16'hFFFF);
    tbl_b[15] = mk(1, 16'h0080, 16'h0000, 16'h0000, 4'd0,  0, 16'hFFFF);
    tbl_b[16] = mk(0, 16'h0480, 16'h0000, 16'h0080, 4'd7,  1, 16'hFBFF);
    tbl_b[17] = mk(1, 16'h0081, 16'h0000, 16'h0000, 4'd0,  0, 16'hFFFF);
    tbl_b[18] = mk(0, 16'h0081, 16'h0000, 16'h0001, 4'd0,  1, 16'hFF7F);
    tbl_b[19] = mk(0, 16'h0081, 16'h0001, 16'h0000, 4'd0,  0, 16'hFF7E);
    tbl_b[20] = mk(0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 16'hFFFF);

    reset = 1'b1; req = '0; pkt_end = '0;

    foreach (tbl_a[i]) run_vec(tbl_a[i]);

    // Fairness: every port in turn, one bubble between grants, ending back at 0.
    for (int k = 1; k <= 16; k++) begin
      oh = 16'd1 << (k % 16);
      step(0, 16'hFFFF, 16'h0000, oh, 4'(k % 16), 1, oh, 0);
      step(0, 16'hFFFF, oh, 16'h0000, 4'd0, 0, 16'h0000, 0);
    end

    foreach (tbl_b[i]) run_vec(tbl_b[i]);

    // Random request sets, released alternately by pkt_end or by dropping the request.
    ptr = 4'd1;
    for (int t = 0; t < 24; t++) begin
      rq = 16'($urandom_range(1, 65535));
      w  = rr_pick(rq, ptr);
      oh = 16'd1 << w;
      step(0, rq, 16'h0000, oh, w, 1, ~(rq & ~oh), 0);
      if (t % 2 == 1) begin
        step(0, rq, oh, 16'h0000, 4'd0, 0, ~rq, 0);
      end else begin
        rq2 = rq & ~oh;
        step(0, rq2, 16'h0000, 16'h0000, 4'd0, 0, ~rq2, 0);
      end
      ptr = w + 4'd1;
    end

`ifdef ROUTER_ARB_TIMEOUT_EN
    step(1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 16'hFFFF, 0);
    step(0, 16'h0004, 16'h0000, 16'h0004, 4'd2, 1, 16'hFFFF, 0);
    for (int k = 0; k < 7; k++) step(0, 16'h0005, 16'h0000, 16'h0004, 4'd2, 1, 16'hFFFE, 0);
    step(0, 16'h0005, 16'h0000, 16'h0000, 4'd0, 0, 16'hFFFA, 1);
    step(0, 16'h0005, 16'h0000, 16'h0001, 4'd0, 1, 16'hFFFB, 0);
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
